gate_sweep_ctrl: RTL
====================

Name: gate_sweep_ctrl

Overview:
- Sequencer that drives the two inputs of a 2-input combinational gate cell through all four input vectors, waits a programmable settle time per vector, then samples the gate output.
- Assembles the samples into a 4-bit truth table, compares it against an expected table, and reports pass/fail plus a per-vector mismatch mask.
- Sits between a gate-under-test instance and a start/abort control source, and replaces hand-written stimulus sequences with an on-chip self-check.

Parameters:
- SETTLE_CYCLES, 4, cycles each vector is held stable before sampling; legal range 1..255.
- EXPECTED, 4'b1000, expected truth table; bit i corresponds to the vector where {b,a} = i. Default is AND.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  level-sampled; begins a sweep when sampled high in IDLE.
- abort  input  1  terminates a sweep in progress; no effect in IDLE or DONE.
- gate_out  input  1  output of the gate under test.
- gate_a  output  1  drives gate input a.
- gate_b  output  1  drives gate input b.
- busy  output  1  high while a sweep is in progress.
- done  output  1  one-cycle pulse when a sweep completes.
- truth_table  output  4  sampled results of the last completed sweep.
- pass  output  1  truth_table == EXPECTED for the last completed sweep.
- fail_mask  output  4  truth_table XOR EXPECTED for the last completed sweep.

Behaviour:
- All outputs are registered.
- Reset (rst high at an edge, in any state, including mid-sweep):
  - State goes to IDLE.
  - gate_a, gate_b, busy, done, truth_table, pass and fail_mask all go to 0.
  - The vector index and settle counter are cleared.
- FSM states are IDLE, SETTLE and DONE.
- IDLE:
  - gate_a = gate_b = 0.
  - If start is sampled high at edge E0, then after E0: state = SETTLE, busy = 1, vector index = 0, and {gate_b, gate_a} = 2'b00.
  - The settle counter is loaded with SETTLE_CYCLES-1.
- SETTLE:
  - The counter decrements on each edge.
  - At the edge where the counter is 0, gate_out is captured into an internal shadow register at bit {gate_b, gate_a}.
  - If the index is below 3: increment the index, drive the next vector on the same edge, and reload the counter.
  - Vector order is index 0..3, with gate_a = idx[0] and gate_b = idx[1]. The resulting sequence of {a,b} is 00, 10, 01, 11.
  - Each vector is held stable for exactly SETTLE_CYCLES cycles.
- Completion:
  - The sample of index 3 happens at edge E0 + 4*SETTLE_CYCLES.
  - On that edge: state = DONE, done = 1, busy = 0, gate_a = gate_b = 0.
  - On the same edge, truth_table is loaded with the full shadow value, including the bit just sampled, and pass and fail_mask are updated from it.
- DONE: lasts exactly one cycle, then the state returns to IDLE and done = 0. start is ignored while in DONE.
- Back-to-back sweeps: with start held high continuously, a new sweep is accepted at E0 + 4*SETTLE_CYCLES + 2. done pulses every 4*SETTLE_CYCLES + 2 cycles.
- start while busy: ignored; it does not restart the sweep.
- abort sampled high in SETTLE:
  - Next state is IDLE, with busy = 0 and gate_a = gate_b = 0.
  - No done pulse is generated.
  - truth_table, pass and fail_mask keep their values from the previous completed sweep; partial samples are discarded.
- start and abort high together in IDLE: start wins. In SETTLE, abort wins.
- Results are stable between sweeps and change only on the completion edge or on reset.
- The settle counter width is $clog2(SETTLE_CYCLES+1). No wrap-around of the counter is permitted.

Test Plan (SETTLE_CYCLES = 4, EXPECTED = 4'b1000):
- Reset, then hold idle for 5 cycles -> gate_a, gate_b, busy, done, truth_table, pass and fail_mask all 0.
- Gate model AND, 1-cycle start pulse at edge E0 -> busy from E0+1; {a,b} = 00, 10, 01, 11, each held 4 cycles; done = 1 for exactly one cycle at E0+16; truth_table = 4'b1000, pass = 1, fail_mask = 4'b0000.
- Gate model OR, start pulse -> truth_table = 4'b1110, pass = 0, fail_mask = 4'b0110; second start pulse during busy produces no restart and the same done timing.
- After an AND pass, abort asserted 6 cycles into an OR sweep -> busy = 0 and gate inputs 00 on the next cycle; no done pulse; truth_table stays 4'b1000 and pass stays 1.
- start held high continuously with the AND model -> done pulses at E0+16, E0+34, E0+52; each sweep yields truth_table = 4'b1000.
- rst asserted at E0+9 mid-sweep -> on the next cycle all outputs are 0 and the state is IDLE; a subsequent start produces a complete, correct sweep.

Source files
------------

// File: rtl/gate_sweep_ctrl.sv
// rtl/gate_sweep_ctrl.sv - exhaustive 2-input gate sweep sequencer with truth-table self-check
module gate_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter logic [3:0]  EXPECTED      = 4'b1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    input  logic       gate_out,
    output logic       gate_a,
    output logic       gate_b,
    output logic       busy,
    output logic       done,
    output logic [3:0] truth_table,
    output logic       pass,
    output logic [3:0] fail_mask
);

    // Counter sized so SETTLE_CYCLES-1 always fits; it never wraps because
    // it is reloaded or the sweep ends whenever it reaches zero.
    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t           state_q;
    logic [1:0]       idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       shadow_q;
    logic [3:0]       shadow_d;
    logic [1:0]       idx_inc;
    logic             gate_a_q;
    logic             gate_b_q;
    logic             busy_q;
    logic             done_q;
    logic [3:0]       truth_table_q;
    logic             pass_q;
    logic [3:0]       fail_mask_q;

    // Shadow with the current sample merged in, so the completion edge can
    // publish all four bits including the one captured on that same edge.
    always_comb begin
        shadow_d        = shadow_q;
        shadow_d[idx_q] = gate_out;
        idx_inc         = idx_q + 2'd1;
    end

    // Sweep FSM: walks idx 0..3 (a = idx[0], b = idx[1]), samples after the
    // settle window and publishes results on the final sample edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            shadow_q      <= 4'd0;
            gate_a_q      <= 1'b0;
            gate_b_q      <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            truth_table_q <= 4'd0;
            pass_q        <= 1'b0;
            fail_mask_q   <= 4'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    gate_a_q <= 1'b0;
                    gate_b_q <= 1'b0;
                    done_q   <= 1'b0;
                    // Abort has no meaning here, so start alone decides.
                    if (start) begin
                        state_q  <= ST_SETTLE;
                        busy_q   <= 1'b1;
                        idx_q    <= 2'd0;
                        cnt_q    <= CNT_LOAD;
                        shadow_q <= 4'd0;
                    end
                end

                ST_SETTLE: begin
                    if (abort) begin
                        // Partial samples stay in the shadow only; published
                        // results keep the previous completed sweep.
                        state_q  <= ST_IDLE;
                        busy_q   <= 1'b0;
                        gate_a_q <= 1'b0;
                        gate_b_q <= 1'b0;
                        idx_q    <= 2'd0;
                        cnt_q    <= '0;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end else begin
                        shadow_q <= shadow_d;
                        if (idx_q != 2'd3) begin
                            idx_q    <= idx_inc;
                            gate_a_q <= idx_inc[0];
                            gate_b_q <= idx_inc[1];
                            cnt_q    <= CNT_LOAD;
                        end else begin
                            state_q       <= ST_DONE;
                            done_q        <= 1'b1;
                            busy_q        <= 1'b0;
                            gate_a_q      <= 1'b0;
                            gate_b_q      <= 1'b0;
                            idx_q         <= 2'd0;
                            truth_table_q <= shadow_d;
                            pass_q        <= (shadow_d == EXPECTED);
                            fail_mask_q   <= shadow_d ^ EXPECTED;
                        end
                    end
                end

                ST_DONE: begin
                    // One-cycle completion state; start is not looked at here.
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                end

                default: begin
                    state_q  <= ST_IDLE;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b0;
                    gate_a_q <= 1'b0;
                    gate_b_q <= 1'b0;
                end
            endcase
        end
    end

    assign gate_a      = gate_a_q;
    assign gate_b      = gate_b_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign truth_table = truth_table_q;
    assign pass        = pass_q;
    assign fail_mask   = fail_mask_q;

endmodule
